// File: rtl/ps2_keyboard_cmd_sequencer_if.sv
// Bundle between the PS/2 command sequencer and its neighbours: received bytes in,
// byte-transmit handshake out, and the filtered byte stream toward the key decoder.
interface ps2_keyboard_cmd_sequencer_if;
   logic       ps2_rx_data__valid;
   logic [7:0] ps2_rx_data__data;
   logic       ps2_rx_data__parity_error;
   logic       ps2_rx_data__protocol_error;
   logic       ps2_rx_data__timeout;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       tx_error;
   logic       fwd_rx_data__valid;
   logic [7:0] fwd_rx_data__data;
   logic       fwd_rx_data__parity_error;
   logic       fwd_rx_data__protocol_error;
   logic       fwd_rx_data__timeout;

   modport master (
      input  ps2_rx_data__valid, ps2_rx_data__data, ps2_rx_data__parity_error,
             ps2_rx_data__protocol_error, ps2_rx_data__timeout, tx_done, tx_error,
      output tx_req, tx_data, fwd_rx_data__valid, fwd_rx_data__data,
             fwd_rx_data__parity_error, fwd_rx_data__protocol_error, fwd_rx_data__timeout
   );

   modport slave (
      output ps2_rx_data__valid, ps2_rx_data__data, ps2_rx_data__parity_error,
             ps2_rx_data__protocol_error, ps2_rx_data__timeout, tx_done, tx_error,
      input  tx_req, tx_data, fwd_rx_data__valid, fwd_rx_data__data,
             fwd_rx_data__parity_error, fwd_rx_data__protocol_error, fwd_rx_data__timeout
   );
endinterface

// File: rtl/ps2_keyboard_cmd_sequencer.sv
// Host-to-keyboard command sequencer: reset/BAT, LED updates, ack/resend/timeout retries.
// Define TYPEMATIC_INIT_EN to append a typematic-rate command after a successful BAT.
module ps2_keyboard_cmd_sequencer #(
   parameter int unsigned ACK_TIMEOUT    = 50000,
   parameter int unsigned BAT_TIMEOUT    = 1000000,
`ifdef TYPEMATIC_INIT_EN
   parameter logic [7:0]  TYPEMATIC_RATE = 8'h20,
`endif
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic                          clk,
   input  logic                          clk__enable,
   input  logic                          reset_n,
   ps2_keyboard_cmd_sequencer_if.master  bus,
   input  logic [2:0]                    led_state,
   input  logic                          led_update,
   input  logic                          reset_request,
   output logic                          busy,
   output logic                          kbd_ready,
   output logic                          cmd_error
);

   localparam logic [23:0] ACK_LAST  = 24'(ACK_TIMEOUT - 1);
   localparam logic [23:0] BAT_LAST  = 24'(BAT_TIMEOUT - 1);
   localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

   typedef enum logic [3:0] {
      IDLE, RST_SEND, RST_ACK, BAT_WAIT, LED_SEND, LED_ACK, LDAT_SEND, LDAT_ACK, ERROR
`ifdef TYPEMATIC_INIT_EN
      , TYP_SEND, TYP_ACK, TDAT_SEND, TDAT_ACK
`endif
   } state_t;

   state_t      state, next_state, step_state, retry_state;
   logic [2:0]  retry_cnt;
   logic [23:0] timer;
   logic [2:0]  led_reg;
   logic        led_pending, reset_pending;
   logic        is_send, in_ack, waiting, expired, advance, resend, set_ready;
   logic        rx_err, rx_ack, rx_nak;
   logic [7:0]  send_byte;

   // Each SEND state names its follow-on ACK state; each ACK state names the SEND state it retries.
   always_comb begin
      next_state  = state;
      step_state  = state;
      retry_state = state;
      is_send     = 1'b0;
      in_ack      = 1'b0;
      waiting     = 1'b0;
      advance     = 1'b0;
      resend      = 1'b0;
      set_ready   = 1'b0;
      send_byte   = 8'h00;
      rx_err  = bus.ps2_rx_data__parity_error | bus.ps2_rx_data__protocol_error |
                bus.ps2_rx_data__timeout;
      rx_ack  = bus.ps2_rx_data__valid && !rx_err && (bus.ps2_rx_data__data == 8'hFA);
      rx_nak  = bus.ps2_rx_data__valid && (rx_err || (bus.ps2_rx_data__data == 8'hFE));
      expired = timer >= ((state == BAT_WAIT) ? BAT_LAST : ACK_LAST);
      case (state)
         IDLE: begin
            if (reset_request || reset_pending)
               next_state = RST_SEND;
            else if (led_pending || led_update)
               next_state = LED_SEND;
         end
         RST_SEND:  begin is_send = 1'b1; send_byte = 8'hFF; step_state = RST_ACK; end
         RST_ACK:   begin in_ack = 1'b1; step_state = BAT_WAIT; retry_state = RST_SEND; end
         BAT_WAIT: begin
            waiting = 1'b1;
            if (bus.ps2_rx_data__valid && !rx_err && (bus.ps2_rx_data__data == 8'hAA)) begin
`ifdef TYPEMATIC_INIT_EN
               next_state = TYP_SEND;
`else
               next_state = IDLE;
               set_ready  = 1'b1;
`endif
            end else if (bus.ps2_rx_data__valid && !rx_err && (bus.ps2_rx_data__data == 8'hFC))
               next_state = ERROR;
            else if (!bus.ps2_rx_data__valid && expired)
               next_state = ERROR;
         end
         LED_SEND:  begin is_send = 1'b1; send_byte = 8'hED; step_state = LED_ACK; end
         LED_ACK:   begin in_ack = 1'b1; step_state = LDAT_SEND; retry_state = LED_SEND; end
         LDAT_SEND: begin is_send = 1'b1; send_byte = {5'b0, led_reg}; step_state = LDAT_ACK; end
         LDAT_ACK:  begin in_ack = 1'b1; step_state = IDLE; retry_state = LDAT_SEND; end
`ifdef TYPEMATIC_INIT_EN
         TYP_SEND:  begin is_send = 1'b1; send_byte = 8'hF3; step_state = TYP_ACK; end
         TYP_ACK:   begin in_ack = 1'b1; step_state = TDAT_SEND; retry_state = TYP_SEND; end
         TDAT_SEND: begin is_send = 1'b1; send_byte = TYPEMATIC_RATE; step_state = TDAT_ACK; end
         TDAT_ACK: begin
            in_ack      = 1'b1;
            step_state  = IDLE;
            retry_state = TDAT_SEND;
            set_ready   = rx_ack;
         end
`endif
         ERROR: begin
            if (reset_request)
               next_state = RST_SEND;
         end
         default: next_state = IDLE;
      endcase
      if (is_send) begin
         if (bus.tx_done)
            next_state = step_state;
         else if (bus.tx_error)
            resend = 1'b1;
      end
      // A byte arriving in the expiry cycle wins; an ignored byte just defers expiry one cycle.
      if (in_ack) begin
         waiting = 1'b1;
         if (rx_ack) begin
            next_state = step_state;
            advance    = 1'b1;
         end else if (rx_nak || (!bus.ps2_rx_data__valid && expired))
            resend = 1'b1;
      end
      if (resend)
         next_state = (retry_cnt < RETRY_MAX) ? retry_state : ERROR;
   end

   // tx_data is loaded in the first SEND cycle, the same edge tx_req rises, so it is stable under tx_req.
   always_ff @(posedge clk) begin
      if (clk__enable) begin
         if (!reset_n) begin
            state                           <= RST_SEND;
            bus.tx_req                      <= 1'b0;
            bus.tx_data                     <= 8'h00;
            retry_cnt                       <= 3'd0;
            timer                           <= 24'd0;
            led_reg                         <= 3'd0;
            led_pending                     <= 1'b0;
            reset_pending                   <= 1'b0;
            busy                            <= 1'b0;
            kbd_ready                       <= 1'b0;
            cmd_error                       <= 1'b0;
            bus.fwd_rx_data__valid          <= 1'b0;
            bus.fwd_rx_data__data           <= 8'h00;
            bus.fwd_rx_data__parity_error   <= 1'b0;
            bus.fwd_rx_data__protocol_error <= 1'b0;
            bus.fwd_rx_data__timeout        <= 1'b0;
         end else begin
            state      <= next_state;
            bus.tx_req <= is_send && (next_state == state) && !bus.tx_error;
            if (is_send && !bus.tx_req)
               bus.tx_data <= send_byte;
            if (advance || state == IDLE || state == ERROR)
               retry_cnt <= 3'd0;
            else if (resend && retry_cnt < RETRY_MAX)
               retry_cnt <= retry_cnt + 3'd1;
            timer <= (waiting && next_state == state) ? timer + 24'd1 : 24'd0;
            if (led_update)
               led_reg <= led_state;
            if (next_state == LED_SEND && state != LED_SEND)
               led_pending <= 1'b0;
            else if (led_update && state != IDLE)
               led_pending <= 1'b1;
            if ((state == IDLE || state == ERROR) && next_state == RST_SEND)
               reset_pending <= 1'b0;
            else if (reset_request && state != IDLE && state != ERROR)
               reset_pending <= 1'b1;
            if ((next_state == RST_SEND && state != RST_SEND) || next_state == ERROR)
               kbd_ready <= 1'b0;
            else if (set_ready)
               kbd_ready <= 1'b1;
            busy      <= (next_state != IDLE) && (next_state != ERROR);
            cmd_error <= (next_state == ERROR);
            bus.fwd_rx_data__valid          <= bus.ps2_rx_data__valid && (state == IDLE);
            bus.fwd_rx_data__data           <= bus.ps2_rx_data__data;
            bus.fwd_rx_data__parity_error   <= bus.ps2_rx_data__parity_error;
            bus.fwd_rx_data__protocol_error <= bus.ps2_rx_data__protocol_error;
            bus.fwd_rx_data__timeout        <= bus.ps2_rx_data__timeout;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_cmd_sequencer.sv
// Directed/randomised bench: acts as transmit engine and keyboard, scoreboards transmitted bytes.
module tb_ps2_keyboard_cmd_sequencer;
   localparam int ACK_TO  = 16;
   localparam int BAT_TO  = 300;
   localparam int RETRIES = 3;

   logic       clk = 1'b0;
   logic       clk__enable;
   logic       reset_n;
   logic [2:0] led_state;
   logic       led_update;
   logic       reset_request;
   logic       busy;
   logic       kbd_ready;
   logic       cmd_error;

   ps2_keyboard_cmd_sequencer_if sif();

   ps2_keyboard_cmd_sequencer #(
      .ACK_TIMEOUT (ACK_TO),
      .BAT_TIMEOUT (BAT_TO),
      .MAX_RETRIES (RETRIES)
   ) dut (
      .clk           (clk),
      .clk__enable   (clk__enable),
      .reset_n       (reset_n),
      .bus           (sif),
      .led_state     (led_state),
      .led_update    (led_update),
      .reset_request (reset_request),
      .busy          (busy),
      .kbd_ready     (kbd_ready),
      .cmd_error     (cmd_error)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] tx_log[$];
   logic [7:0] exp_log[$];
   int         checked = 0;
   int         fwd_count = 0;
   int         exp_fwd = 0;
   logic       tx_prev = 1'b0;

   // Every rising edge of tx_req is one transmission attempt of the byte on tx_data.
   always @(negedge clk) begin
      if (sif.tx_req && !tx_prev)
         tx_log.push_back(sif.tx_data);
      tx_prev = sif.tx_req;
      if (sif.fwd_rx_data__valid)
         fwd_count++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_state(input string tag, input logic exp_busy, input logic exp_ready,
                              input logic exp_err);
      check_output({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check_output({tag, "_kbd_ready"}, 32'(kbd_ready), 32'(exp_ready));
      check_output({tag, "_cmd_error"}, 32'(cmd_error), 32'(exp_err));
   endtask

   task automatic check_log(input string tag);
      check_output({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_log.size()));
      if (tx_log.size() == exp_log.size()) begin
         for (int i = checked; i < exp_log.size(); i++)
            check_output({tag, "_tx_byte"}, 32'(tx_log[i]), 32'(exp_log[i]));
         checked = exp_log.size();
      end
   endtask

   task automatic apply_led_update(input logic [2:0] val);
      led_state  = val;
      led_update = 1'b1;
      tick();
      led_update = 1'b0;
   endtask

   task automatic apply_reset_request();
      reset_request = 1'b1;
      tick();
      reset_request = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic [2:0] errs);
      repeat ($urandom_range(0, 2)) tick();
      sif.ps2_rx_data__valid          = 1'b1;
      sif.ps2_rx_data__data           = d;
      sif.ps2_rx_data__parity_error   = errs[0];
      sif.ps2_rx_data__protocol_error = errs[1];
      sif.ps2_rx_data__timeout        = errs[2];
      tick();
      sif.ps2_rx_data__valid          = 1'b0;
      sif.ps2_rx_data__parity_error   = 1'b0;
      sif.ps2_rx_data__protocol_error = 1'b0;
      sif.ps2_rx_data__timeout        = 1'b0;
   endtask

   function automatic logic [7:0] junk_byte();
      logic [7:0] j = 8'($urandom);
      if (j == 8'hFA || j == 8'hFE)
         j = 8'h3C;
      return j;
   endfunction

   task automatic wait_tx(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (sif.tx_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_idle(input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (busy === 1'b0 && sif.tx_req === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_output({tag, "_idle_reached"}, 32'(ok), 32'd1);
   endtask

   // Keyboard model for one command byte: naks negative answers, then ack (if good_end).
   // nak kinds: 0 tx_error, 1 reply 0xFE, 2 reply with error flag, 3 silence; -1 = random.
   task automatic exchange(input logic [7:0] exp_byte, input int naks, input bit good_end,
                           input int nak_kind);
      logic ok;
      int   kind;
      for (int i = 0; i <= naks; i++) begin
         wait_tx(ok);
         check_output("tx_req_rise", 32'(ok), 32'd1);
         if (!ok)
            return;
         exp_log.push_back(exp_byte);
         check_output("tx_data", 32'(sif.tx_data), 32'(exp_byte));
         repeat ($urandom_range(0, 2)) tick();
         if (i == naks && good_end)
            kind = 4;
         else if (nak_kind < 0)
            kind = int'($urandom_range(0, 3));
         else
            kind = nak_kind;
         if (kind == 0) begin
            sif.tx_error = 1'b1;
            tick();
            sif.tx_error = 1'b0;
         end else begin
            sif.tx_done = 1'b1;
            tick();
            sif.tx_done = 1'b0;
            if (kind == 1)
               rx_byte(8'hFE, 3'b000);
            else if (kind == 2)
               rx_byte(8'($urandom), 3'($urandom_range(1, 7)));
            else if (kind == 4) begin
               if ($urandom_range(0, 1) == 1)
                  rx_byte(junk_byte(), 3'b000);
               rx_byte(8'hFA, 3'b000);
            end
         end
      end
   endtask

   task automatic good_reset_sequence(input int naks);
      exchange(8'hFF, naks, 1'b1, -1);
      rx_byte(8'hAA, 3'b000);
   endtask

   task automatic led_sequence(input logic [2:0] led, input int naks_cmd, input int naks_data);
      exchange(8'hED, naks_cmd, 1'b1, -1);
      exchange({5'b0, led}, naks_data, 1'b1, -1);
   endtask

   initial begin
      logic [2:0] led_a;
      logic [2:0] led_b;
      logic [7:0] fwd_byte;
      logic [2:0] fwd_errs;
      logic       ok;

      clk__enable   = 1'b1;
      reset_n       = 1'b0;
      led_state     = 3'd0;
      led_update    = 1'b0;
      reset_request = 1'b0;
      sif.ps2_rx_data__valid          = 1'b0;
      sif.ps2_rx_data__data           = 8'h00;
      sif.ps2_rx_data__parity_error   = 1'b0;
      sif.ps2_rx_data__protocol_error = 1'b0;
      sif.ps2_rx_data__timeout        = 1'b0;
      sif.tx_done                     = 1'b0;
      sif.tx_error                    = 1'b0;
      repeat (3) tick();
      check_output("reset_tx_req", 32'(sif.tx_req), 32'd0);
      check_output("reset_tx_data", 32'(sif.tx_data), 32'd0);
      check_output("reset_fwd_valid", 32'(sif.fwd_rx_data__valid), 32'd0);
      check_state("reset", 1'b0, 1'b0, 1'b0);

      $display("[TB] power-up reset sequence");
      reset_n = 1'b1;
      good_reset_sequence(0);
      check_state("powerup", 1'b0, 1'b1, 1'b0);
      check_log("powerup");
      check_output("powerup_no_fwd", 32'(fwd_count), 32'(exp_fwd));

      $display("[TB] LED update from idle and forwarding");
      apply_led_update(3'b101);
      led_sequence(3'b101, 0, 0);
      wait_idle("led101");
      check_state("led101", 1'b0, 1'b1, 1'b0);
      check_log("led101");
      fwd_byte = 8'h1C;
      fwd_errs = 3'($urandom);
      sif.ps2_rx_data__valid          = 1'b1;
      sif.ps2_rx_data__data           = fwd_byte;
      sif.ps2_rx_data__parity_error   = fwd_errs[0];
      sif.ps2_rx_data__protocol_error = fwd_errs[1];
      sif.ps2_rx_data__timeout        = fwd_errs[2];
      tick();
      sif.ps2_rx_data__valid          = 1'b0;
      sif.ps2_rx_data__parity_error   = 1'b0;
      sif.ps2_rx_data__protocol_error = 1'b0;
      sif.ps2_rx_data__timeout        = 1'b0;
      exp_fwd++;
      check_output("fwd_valid", 32'(sif.fwd_rx_data__valid), 32'd1);
      check_output("fwd_data", 32'(sif.fwd_rx_data__data), 32'(fwd_byte));
      check_output("fwd_flags", 32'({sif.fwd_rx_data__timeout, sif.fwd_rx_data__protocol_error,
                                     sif.fwd_rx_data__parity_error}), 32'(fwd_errs));
      tick();
      check_output("fwd_valid_pulse", 32'(sif.fwd_rx_data__valid), 32'd0);

      $display("[TB] LED data resent twice");
      apply_led_update(3'b101);
      exchange(8'hED, 0, 1'b1, -1);
      exchange(8'h05, 2, 1'b1, 1);
      wait_idle("resend2");
      check_state("resend2", 1'b0, 1'b1, 1'b0);
      check_log("resend2");

      $display("[TB] randomised LED updates with retries");
      for (int r = 0; r < 5; r++) begin
         led_a = 3'($urandom);
         apply_led_update(led_a);
         led_sequence(led_a, int'($urandom_range(0, RETRIES)), int'($urandom_range(0, RETRIES)));
         wait_idle("rand_led");
         check_state("rand_led", 1'b0, 1'b1, 1'b0);
         check_log("rand_led");
      end

      $display("[TB] silent keyboard exhausts retries");
      apply_reset_request();
      exchange(8'hFF, RETRIES, 1'b0, 3);
      repeat (ACK_TO + 5) tick();
      check_state("no_ack", 1'b0, 1'b0, 1'b1);
      check_log("no_ack");
      apply_reset_request();
      good_reset_sequence(0);
      check_state("no_ack_recover", 1'b0, 1'b1, 1'b0);
      check_log("no_ack_recover");

      $display("[TB] BAT failure, LED request held in error");
      apply_reset_request();
      exchange(8'hFF, 0, 1'b1, -1);
      rx_byte(8'hFC, 3'b000);
      check_state("bat_fail", 1'b0, 1'b0, 1'b1);
      led_a = 3'($urandom);
      apply_led_update(led_a);
      repeat (30) tick();
      check_output("error_no_tx", 32'(sif.tx_req), 32'd0);
      check_log("error_hold");
      apply_reset_request();
      good_reset_sequence(int'($urandom_range(0, RETRIES)));
      led_sequence(led_a, 0, 0);
      wait_idle("bat_recover");
      check_state("bat_recover", 1'b0, 1'b1, 1'b0);
      check_log("bat_recover");

      $display("[TB] LED requests during reset sequence coalesce");
      apply_reset_request();
      apply_led_update(3'b001);
      apply_led_update(3'b110);
      good_reset_sequence(0);
      led_sequence(3'b110, 0, 0);
      wait_idle("coalesce");
      repeat (30) tick();
      check_state("coalesce", 1'b0, 1'b1, 1'b0);
      check_log("coalesce");

      $display("[TB] LED data retries exhausted");
      led_a = 3'($urandom);
      apply_led_update(led_a);
      exchange(8'hED, 0, 1'b1, -1);
      exchange({5'b0, led_a}, RETRIES, 1'b0, -1);
      repeat (ACK_TO + 5) tick();
      check_state("led_fail", 1'b0, 1'b0, 1'b1);
      check_log("led_fail");

      $display("[TB] BAT timeout");
      apply_reset_request();
      exchange(8'hFF, 0, 1'b1, -1);
      repeat (BAT_TO + 10) tick();
      check_state("bat_timeout", 1'b0, 1'b0, 1'b1);
      apply_reset_request();
      good_reset_sequence(0);
      check_state("bat_timeout_recover", 1'b0, 1'b1, 1'b0);
      check_log("bat_timeout_recover");

      $display("[TB] clock enable low freezes state and reset");
      clk__enable   = 1'b0;
      reset_n       = 1'b0;
      led_update    = 1'b1;
      reset_request = 1'b1;
      repeat (3) tick();
      check_state("clk_enable_low", 1'b0, 1'b1, 1'b0);
      check_output("clk_enable_low_tx_req", 32'(sif.tx_req), 32'd0);
      reset_n       = 1'b1;
      led_update    = 1'b0;
      reset_request = 1'b0;
      clk__enable   = 1'b1;
      repeat (20) tick();
      check_log("clk_enable_low");

      $display("[TB] reset mid-transfer");
      apply_reset_request();
      wait_tx(ok);
      check_output("mid_tx_req_rise", 32'(ok), 32'd1);
      exp_log.push_back(8'hFF);
      reset_n = 1'b0;
      tick();
      check_output("mid_reset_tx_req", 32'(sif.tx_req), 32'd0);
      check_state("mid_reset", 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      good_reset_sequence(0);
      check_state("mid_reset_recover", 1'b0, 1'b1, 1'b0);
      check_log("mid_reset_recover");
      check_output("fwd_total", 32'(fwd_count), 32'(exp_fwd));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_cmd_sequencer.md
Name: ps2_keyboard_cmd_sequencer

Overview:
Controller that sequences host-to-keyboard commands over a PS/2 host transmit path: reset/BAT at power-up, and LED updates on request. It sits between ps2_host (rx bytes plus a byte-transmit engine) and ps2_host_keyboard. It handles ack (0xFA), resend (0xFE) and timeouts with bounded retries. Keyboard rx bytes are forwarded to the key decoder only when the sequencer is idle; command responses are consumed.

Parameters:
ACK_TIMEOUT, 50000, clk cycles to wait for a response byte after tx_done (1..65535)
BAT_TIMEOUT, 1000000, clk cycles to wait for the BAT result after the reset ack (24-bit counter)
MAX_RETRIES, 3, retransmissions allowed per byte before error (0..7)
TYPEMATIC_RATE, 8'h20, typematic byte sent when TYPEMATIC_INIT_EN is defined

Ports:
clk  in  1  single clock; all state on the rising edge
clk__enable  in  1  clock enable; no state changes when low, including reset
reset_n  in  1  synchronous, active-low reset
ps2_rx_data__valid/__data/__parity_error/__protocol_error/__timeout  in  1/8/1/1/1  received byte from ps2_host
tx_done  in  1  pulse: transmit engine finished the current byte
tx_error  in  1  pulse: transmit aborted (device did not clock/ack)
led_state  in  3  {caps,num,scroll}; sampled on led_update
led_update  in  1  pulse: request an LED update
reset_request  in  1  pulse: re-run the keyboard reset sequence
tx_req  out  1  level: transmit tx_data; held until tx_done or tx_error
tx_data  out  8  byte to transmit; stable while tx_req is high
fwd_rx_data__valid/__data/__parity_error/__protocol_error/__timeout  out  1/8/1/1/1  rx forwarded to ps2_host_keyboard
busy  out  1  state is not IDLE or ERROR
kbd_ready  out  1  last reset sequence succeeded and not in ERROR
cmd_error  out  1  in ERROR state

Behaviour:
- Reset (reset_n=0 with clk__enable=1):
  - All outputs are 0, tx_data=0, retry count=0, pending flag=0, led register=0.
  - First state after reset is RST_SEND, so the sequencer auto-resets the keyboard.
- States and transitions:
  - IDLE -> RST_SEND on reset_request. Otherwise IDLE -> LED_SEND if an LED update is pending or led_update is high. reset_request wins over an LED update.
  - RST_SEND transmits 0xFF, then goes to RST_ACK.
  - RST_ACK goes to BAT_WAIT on 0xFA.
  - BAT_WAIT on 0xAA: kbd_ready=1, go to IDLE. On 0xFC: go to ERROR. On timeout: go to ERROR.
  - LED_SEND transmits 0xED, then goes to LED_ACK.
  - LED_ACK goes to LDAT_SEND on 0xFA.
  - LDAT_SEND transmits {5'b0,caps,num,scroll}, then goes to LDAT_ACK.
  - LDAT_ACK goes to IDLE on 0xFA.
  - ERROR -> RST_SEND on reset_request only.
- SEND states:
  - tx_req rises the cycle after entry. tx_data is loaded on entry.
  - tx_done: go to the ACK state, clear the timeout counter. tx_error: treated as a resend.
- ACK states (any byte with valid=1):
  - 0xFA: advance and clear the retry count.
  - 0xFE, any error flag, or timeout expiry: resend. If retry count < MAX_RETRIES, increment it and return to the same SEND state (same byte). Otherwise go to ERROR.
  - Any other byte is ignored and not forwarded.
- Timeout counter:
  - Counts cycles in ACK/BAT_WAIT. Expiry is when count == ACK_TIMEOUT-1 (or BAT_TIMEOUT-1 in BAT_WAIT).
  - A valid byte in the expiry cycle takes priority over the timeout.
- LED requests:
  - led_update while busy sets the pending flag and latches led_state; the latest request wins.
  - The pending flag clears on entry to LED_SEND.
  - In ERROR, led_update is latched but not serviced until after a successful reset.
- Resend scope: a resend during LDAT_* retransmits only the data byte, not 0xED.
- Forwarding:
  - fwd_rx_data__* equals ps2_rx_data__* registered by one cycle when the state is IDLE in the cycle of valid. Otherwise fwd valid=0.
  - Other fwd fields carry the registered data regardless.
- kbd_ready:
  - Clears on entry to RST_SEND and in ERROR.
  - LED sequences do not clear it; a failed LED sequence goes to ERROR, which clears it.
- reset_request while busy is latched and serviced on return to IDLE. reset_request in ERROR is acted on immediately.
- reset_n low mid-transfer drops tx_req in the next cycle. The external engine must abort.

Optional Feature:
- TYPEMATIC_INIT_EN defined:
  - After 0xAA in BAT_WAIT, go to TYP_SEND (0xF3) -> TYP_ACK -> TDAT_SEND (TYPEMATIC_RATE) -> TDAT_ACK -> IDLE.
  - Same ack/retry rules apply. kbd_ready is set on the final 0xFA, not on 0xAA.
- TYPEMATIC_INIT_EN undefined: the states are absent and BAT 0xAA goes directly to IDLE.

Test Plan:
1. Release reset; model replies with tx_done then 0xFA, then 0xAA -> tx_data=0xFF seen once, kbd_ready=1 and busy=0 after 0xAA; no fwd valid during the sequence.
2. From IDLE: led_state=3'b101, led_update -> bytes 0xED then 0x05 transmitted, each acked by 0xFA; IDLE afterwards; the rx byte 0x1C afterwards appears on fwd one cycle later.
3. LED data byte answered 0xFE twice, then 0xFA -> 0x05 transmitted 3 times total, 0xED once; no error.
4. ACK_TIMEOUT=16, no response to 0xFF -> 4 transmissions of 0xFF (1 + 3 retries) spaced by timeouts, then cmd_error=1, kbd_ready=0; a reset_request pulse restarts with 0xFF.
5. BAT replies 0xFC -> ERROR; led_update in ERROR causes no tx_req; reset_request then a good BAT -> IDLE, then the pending LED sequence runs.
6. led_update pulses with 3'b001 then 3'b110 during the reset sequence -> after BAT, exactly one LED sequence, with data 0x06.
